// File: rtl/chunk_upscaler_if.sv
// ---------------------------------------------------------------------------
// chunk_upscaler_if -- pixel stream bundle for chunk_upscaler.
//
// Handshake: a beat transfers on a rising clk edge when the producer's
// valid and the consumer's ready are both high. A producer never retracts
// a raised valid, and keeps its data/flags stable, until the beat transfers.
//
//   in_data   [PIX_W]  input pixel (R in MSBs, then G, then B)
//   in_valid           input pixel valid
//   in_sof             input pixel is the first of a frame
//   in_ready           upscaler accepts an input pixel
//   out_data  [PIX_W]  output pixel
//   out_valid          output pixel valid
//   out_ready          downstream accepts an output pixel
//   out_sof            first output pixel of a frame
//   out_eol            last output pixel of an output row
//
// Modports: master = stream source/sink side (testbench / neighbours),
//           slave  = the upscaler itself.
// ---------------------------------------------------------------------------
interface chunk_upscaler_if #(
  parameter int PIX_W = 24
);
  logic [PIX_W-1:0] in_data;
  logic             in_valid;
  logic             in_sof;
  logic             in_ready;
  logic [PIX_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sof;
  logic             out_eol;

  modport master (
    output in_data, in_valid, in_sof, out_ready,
    input  in_ready, out_data, out_valid, out_sof, out_eol
  );

  modport slave (
    input  in_data, in_valid, in_sof, out_ready,
    output in_ready, out_data, out_valid, out_sof, out_eol
  );
endinterface

// File: rtl/chunk_upscaler.sv
// ---------------------------------------------------------------------------
// chunk_upscaler -- integer line upscaler.
//
// Loads one line of W input pixels into a line buffer (LOAD), then emits
// S rows of W*S pixels (EMIT), each input pixel repeated S times per row.
// W = line_width clamped to [1,MAX_WIDTH], S = scale_sel clamped to
// [1,MAX_SCALE]; both are captured with the first pixel of a line.
//
// Optional feature: define UPSCALE_HBLEND_EN to replace replicas 1..S-1 of
// each pixel with the per-channel floor average of that pixel and its right
// neighbour (the last pixel uses itself as neighbour). Handshake, timing and
// flags are the same in both builds.
//
// Ports:
//   clk         rising-edge clock
//   resetn      synchronous active-low reset
//   line_width  input pixels per line
//   scale_sel   upscale factor
//   bus         stream interface (slave modport), see chunk_upscaler_if
//   resync      one-cycle pulse: in_sof arrived mid-line, line restarted
//   dbg_state   current FSM state (0 = LOAD, 1 = EMIT)
// ---------------------------------------------------------------------------
module chunk_upscaler #(
  parameter int PIX_W     = 24,
  parameter int MAX_WIDTH = 64,
  parameter int MAX_SCALE = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [$clog2(MAX_WIDTH+1)-1:0] line_width,
  input  logic [$clog2(MAX_SCALE+1)-1:0] scale_sel,
  chunk_upscaler_if.slave                bus,
  output logic                           resync,
  output logic                           dbg_state
);

  localparam int WW = $clog2(MAX_WIDTH + 1);
  localparam int SW = $clog2(MAX_SCALE + 1);
  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int CH = PIX_W / 3;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            run_q, run_d;          // low only in the cycle right after reset
  logic [WW-1:0]   wr_idx_q, wr_idx_d;
  logic [WW-1:0]   w_q, w_d;
  logic [SW-1:0]   s_q, s_d;
  logic [SW-1:0]   row_q, row_d;
  logic [WW-1:0]   col_q, col_d;
  logic [SW-1:0]   rep_q, rep_d;
  logic            sof_flag_q, sof_flag_d;
  logic            resync_q, resync_d;

  logic [PIX_W-1:0] line_buf_q [2**AW];
  logic             buf_we;
  logic [AW-1:0]    buf_waddr;
  logic [PIX_W-1:0] buf_wdata;

  logic [WW-1:0]    w_in, w_cur, wr_pos;
  logic [SW-1:0]    s_in, s_cur;
  logic             in_ready_int, emit, in_fire, out_fire, restart, first_pix;
  logic             last_rep, last_col, last_row;
  logic [PIX_W-1:0] pix_cur, pix_emit;

  // Clamp the line parameters into their legal ranges.
  assign w_in = (line_width == '0)            ? WW'(1) :
                (line_width > WW'(MAX_WIDTH)) ? WW'(MAX_WIDTH) : line_width;
  assign s_in = (scale_sel == '0)             ? SW'(1) :
                (scale_sel > SW'(MAX_SCALE))  ? SW'(MAX_SCALE) : scale_sel;

  assign emit         = (state_q == EMIT);
  assign in_ready_int = (state_q == LOAD) && run_q;
  assign in_fire      = bus.in_valid && in_ready_int;
  assign out_fire     = bus.out_ready && emit;

  // A mid-line in_sof restarts the line: that pixel becomes index 0.
  assign restart   = in_fire && bus.in_sof && (wr_idx_q != '0);
  assign first_pix = (wr_idx_q == '0) || restart;
  assign w_cur     = first_pix ? w_in : w_q;
  assign s_cur     = first_pix ? s_in : s_q;
  assign wr_pos    = restart ? '0 : wr_idx_q;

  assign last_rep = (rep_q == s_q - SW'(1));
  assign last_col = (col_q == w_q - WW'(1));
  assign last_row = (row_q == s_q - SW'(1));

  always_comb begin
    state_d    = state_q;
    run_d      = 1'b1;
    wr_idx_d   = wr_idx_q;
    w_d        = w_q;
    s_d        = s_q;
    row_d      = row_q;
    col_d      = col_q;
    rep_d      = rep_q;
    sof_flag_d = sof_flag_q;
    resync_d   = 1'b0;
    buf_we     = 1'b0;
    buf_waddr  = wr_pos[AW-1:0];
    buf_wdata  = bus.in_data;

    if (state_q == LOAD) begin
      if (in_fire) begin
        buf_we   = 1'b1;
        w_d      = w_cur;
        s_d      = s_cur;
        resync_d = restart;
        if (first_pix) begin
          sof_flag_d = bus.in_sof;
        end
        if (wr_pos + WW'(1) == w_cur) begin
          state_d  = EMIT;
          wr_idx_d = '0;
        end else begin
          wr_idx_d = wr_pos + WW'(1);
        end
      end
    end else begin
      // Counters nest as replica -> column -> row; they all wrap to 0
      // together on the final pixel so the next line starts clean.
      if (out_fire) begin
        if (!last_rep) begin
          rep_d = rep_q + SW'(1);
        end else begin
          rep_d = '0;
          if (!last_col) begin
            col_d = col_q + WW'(1);
          end else begin
            col_d = '0;
            if (!last_row) begin
              row_d = row_q + SW'(1);
            end else begin
              row_d   = '0;
              state_d = LOAD;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= LOAD;
      run_q      <= 1'b0;
      wr_idx_q   <= '0;
      w_q        <= '0;
      s_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      rep_q      <= '0;
      sof_flag_q <= 1'b0;
      resync_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      wr_idx_q   <= wr_idx_d;
      w_q        <= w_d;
      s_q        <= s_d;
      row_q      <= row_d;
      col_q      <= col_d;
      rep_q      <= rep_d;
      sof_flag_q <= sof_flag_d;
      resync_q   <= resync_d;
    end
  end

  // Line buffer: contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      line_buf_q[buf_waddr] <= buf_wdata;
    end
  end

  // Outputs are decoded from registered counters, so they hold by
  // construction while a beat is stalled.
  assign pix_cur = line_buf_q[col_q[AW-1:0]];

`ifdef UPSCALE_HBLEND_EN
  logic [WW-1:0]    col_nxt;
  logic [PIX_W-1:0] pix_nxt;
  logic [PIX_W-1:0] pix_avg;

  assign col_nxt = last_col ? col_q : col_q + WW'(1);
  assign pix_nxt = line_buf_q[col_nxt[AW-1:0]];

  for (genvar c = 0; c < 3; c++) begin : g_avg
    logic [CH:0] sum;
    assign sum = {1'b0, pix_cur[c*CH +: CH]} + {1'b0, pix_nxt[c*CH +: CH]};
    assign pix_avg[c*CH +: CH] = CH'(sum >> 1);
  end

  assign pix_emit = (rep_q == '0) ? pix_cur : pix_avg;
`else
  assign pix_emit = pix_cur;
`endif

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = emit;
  assign bus.out_data  = emit ? pix_emit : '0;
  assign bus.out_sof   = emit && sof_flag_q && (row_q == '0) && (col_q == '0) && (rep_q == '0);
  assign bus.out_eol   = emit && last_rep && last_col;
  assign resync        = resync_q;
  assign dbg_state     = (state_q == EMIT);

endmodule

// File: tb/tb_chunk_upscaler.sv
// ---------------------------------------------------------------------------
// tb_chunk_upscaler -- self-checking bench for chunk_upscaler.
// Expected output streams come from a nested-loop model of the upscaler's
// row/pixel/replica rules; every check is an immediate assertion.
// ---------------------------------------------------------------------------
module tb_chunk_upscaler;
  localparam int PIX_W     = 24;
  localparam int MAX_WIDTH = 64;
  localparam int MAX_SCALE = 4;
  localparam int CH        = PIX_W / 3;

  logic       clk;
  logic       resetn;
  logic [6:0] line_width;
  logic [2:0] scale_sel;
  logic       resync;
  logic       dbg_state;

  chunk_upscaler_if #(.PIX_W(PIX_W)) bus ();

  chunk_upscaler #(
    .PIX_W(PIX_W), .MAX_WIDTH(MAX_WIDTH), .MAX_SCALE(MAX_SCALE)
  ) dut (
    .clk(clk), .resetn(resetn), .line_width(line_width), .scale_sel(scale_sel),
    .bus(bus), .resync(resync), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [PIX_W+1:0] exp_q[$];   // {sof, eol, data}
  logic [PIX_W-1:0] line_q[$];  // pixels of the line being loaded

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, input int hi);
    if (v < 1) return 1;
    if (v > hi) return hi;
    return v;
  endfunction

`ifdef UPSCALE_HBLEND_EN
  function automatic logic [PIX_W-1:0] blend(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    logic [PIX_W-1:0] r;
    int x, y;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      x = int'((a >> (c * CH)) & PIX_W'((1 << CH) - 1));
      y = int'((b >> (c * CH)) & PIX_W'((1 << CH) - 1));
      r = r | (PIX_W'((x + y) / 2) << (c * CH));
    end
    return r;
  endfunction
`endif

  // Reference: S rows; per row every pixel of line_q, S replicas each.
  task automatic build_exp(input int s, input bit sof);
    int w;
    logic [PIX_W-1:0] d;
    w = line_q.size();
    for (int r = 0; r < s; r++)
      for (int i = 0; i < w; i++)
        for (int k = 0; k < s; k++) begin
          d = line_q[i];
`ifdef UPSCALE_HBLEND_EN
          if (k > 0) d = blend(line_q[i], line_q[(i + 1 < w) ? i + 1 : w - 1]);
`endif
          exp_q.push_back({(sof && r == 0 && i == 0 && k == 0), (i == w - 1 && k == s - 1), d});
        end
  endtask

  // ---------------- drivers ----------------
  task automatic send_pixel(input logic [PIX_W-1:0] d, input bit s);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_data  = d;
    bus.in_sof   = s;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic load_line(input int lw, input int ss, input bit sof);
    line_width = 7'(lw);
    scale_sel  = 3'(ss);
    for (int i = 0; i < line_q.size(); i++) send_pixel(line_q[i], (i == 0) ? sof : 1'b0);
  endtask

  // mode 0: always ready, 1: ready toggles 1/0, 2: random ready
  task automatic collect(input int mode, input int max_n);
    int n, guard;
    logic [PIX_W+1:0] e;
    n = 0;
    guard = 0;
    while (exp_q.size() > 0 && n < max_n && guard < 3000) begin
      @(negedge clk);
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (guard % 2 == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      e = exp_q[0];
      chk("out_valid", 32'(bus.out_valid), 1);
      chk("out_data", 32'(bus.out_data), 32'(e[PIX_W-1:0]));
      chk("out_sof", 32'(bus.out_sof), 32'(e[PIX_W+1]));
      chk("out_eol", 32'(bus.out_eol), 32'(e[PIX_W]));
      if (bus.out_ready && bus.out_valid) begin
        void'(exp_q.pop_front());
        n++;
      end
      guard++;
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_line(input int lw, input int ss, input bit sof, input int mode);
    int w, s;
    w = clamp(lw, MAX_WIDTH);
    s = clamp(ss, MAX_SCALE);
    line_q.delete();
    for (int i = 0; i < w; i++) line_q.push_back(PIX_W'($urandom));
    build_exp(s, sof);
    load_line(lw, ss, sof);
    collect(mode, 1 << 30);
    chk("exp_drained", 32'(exp_q.size()), 0);
    @(negedge clk);
    chk("ready_after_line", 32'(bus.in_ready), 1);
    chk("idle_after_line", 32'(bus.out_valid), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    resetn        = 1'b0;
    line_width    = '0;
    scale_sel     = '0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_sof", 32'(bus.out_sof), 0);
    chk("rst_out_eol", 32'(bus.out_eol), 0);
    chk("rst_resync", 32'(resync), 0);
    chk("rst_state", 32'(dbg_state), 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.in_ready), 1);

    // W=4,S=2 with sof, continuous ready
    run_line(4, 2, 1'b1, 0);
    // W=4,S=3 with stalls on alternate cycles
    run_line(4, 3, 1'b0, 1);
    // Clamp: W=0 -> 1, S=7 -> 4
    run_line(0, 7, 1'b1, 0);
    // Pass-through W=1,S=1
    run_line(1, 1, 1'b1, 0);
    run_line(1, 1, 1'b0, 2);

    // Mid-line in_sof restarts the line with a resampled width
    line_q.delete();
    for (int i = 0; i < 5; i++) line_q.push_back(PIX_W'($urandom));
    line_width = 7'd4;
    scale_sel  = 3'd2;
    send_pixel(line_q[0], 1'b0);
    send_pixel(line_q[1], 1'b0);
    chk("no_resync", 32'(resync), 0);
    chk("load_no_valid", 32'(bus.out_valid), 0);
    line_width = 7'd3;
    send_pixel(line_q[2], 1'b1);
    chk("resync_pulse", 32'(resync), 1);
    send_pixel(line_q[3], 1'b0);
    chk("resync_once", 32'(resync), 0);
    void'(line_q.pop_front());
    void'(line_q.pop_front());
    build_exp(2, 1'b1);
    send_pixel(line_q[2], 1'b0);
    collect(0, 1 << 30);
    chk("resync_drained", 32'(exp_q.size()), 0);

    // Reset during EMIT row 1
    line_q.delete();
    for (int i = 0; i < 3; i++) line_q.push_back(PIX_W'($urandom));
    build_exp(2, 1'b1);
    load_line(3, 2, 1'b1);
    collect(0, 8);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("rst_emit_valid", 32'(bus.out_valid), 0);
    chk("rst_emit_ready", 32'(bus.in_ready), 0);
    exp_q.delete();
    @(negedge clk);
    chk("rst_emit_ready1", 32'(bus.in_ready), 1);
    chk("rst_emit_valid1", 32'(bus.out_valid), 0);
    run_line(3, 2, 1'b1, 0);

    // Width above MAX_WIDTH clamps to MAX_WIDTH
    run_line(100, 1, 1'b1, 2);

    // Randomized lines with random back-pressure
    repeat (10) run_line($urandom_range(1, 10), $urandom_range(1, 4), 1'($urandom_range(0, 1)), 2);

`ifdef UPSCALE_HBLEND_EN
    // Directed blend: 000000, FEFEFE at S=2
    line_q.delete();
    line_q.push_back(24'h000000);
    line_q.push_back(24'hFEFEFE);
    exp_q.push_back({1'b1, 1'b0, 24'h000000});
    exp_q.push_back({1'b0, 1'b0, 24'h7F7F7F});
    exp_q.push_back({1'b0, 1'b0, 24'hFEFEFE});
    exp_q.push_back({1'b0, 1'b1, 24'hFEFEFE});
    exp_q.push_back({1'b0, 1'b0, 24'h000000});
    exp_q.push_back({1'b0, 1'b0, 24'h7F7F7F});
    exp_q.push_back({1'b0, 1'b0, 24'hFEFEFE});
    exp_q.push_back({1'b0, 1'b1, 24'hFEFEFE});
    load_line(2, 2, 1'b1);
    collect(1, 1 << 30);
    chk("blend_drained", 32'(exp_q.size()), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
